// File: rtl/plab5_mcore_mem_guard_queue.sv
// Domain-tagged request queue guarding one memory slice: permitted requests go to memory, denied ones are answered locally.
// Optional deny statistics counter enabled by defining PLAB5_MCORE_MEM_GUARD_STATS_EN.
module plab5_mcore_mem_guard_queue #(
  parameter int  p_opaque_nbits = 8,
  parameter int  p_addr_nbits   = 32,
  parameter int  p_data_nbits   = 128,
  parameter int  p_num_entries  = 4,
  localparam int CREQ = 3 + p_opaque_nbits + p_addr_nbits + 4,
  localparam int CRSP = 3 + p_opaque_nbits + 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_sec_level,
  input  logic                    net_req_val,
  output logic                    net_req_rdy,
  input  logic [CREQ-1:0]         net_req_control,
  input  logic [p_data_nbits-1:0] net_req_data,
  input  logic                    net_req_domain,
  output logic                    mem_req_val,
  input  logic                    mem_req_rdy,
  output logic [CREQ-1:0]         mem_req_control,
  output logic [p_data_nbits-1:0] mem_req_data,
  input  logic                    mem_resp_val,
  output logic                    mem_resp_rdy,
  input  logic [CRSP-1:0]         mem_resp_control,
  input  logic [p_data_nbits-1:0] mem_resp_data,
  output logic                    net_resp_val,
  input  logic                    net_resp_rdy,
  output logic [CRSP-1:0]         net_resp_control,
  output logic [p_data_nbits-1:0] net_resp_data,
  output logic                    net_resp_domain,
  output logic [15:0]             deny_count
);

  localparam int PW = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(p_num_entries - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(p_num_entries);

  typedef enum logic {S_PASS, S_DENY} state_t;
  state_t state_q, state_d;

  logic [CREQ-1:0]         ctrl_mem_q [p_num_entries];
  logic [p_data_nbits-1:0] data_mem_q [p_num_entries];
  logic [p_num_entries-1:0] dom_mem_q;
  logic [p_num_entries-1:0] tag_mem_q;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [CW-1:0] tag_cnt_q, tag_cnt_d;

  logic            q_empty, q_full, tag_empty, tag_full;
  logic            enq, deq, deq_deny, tag_push, tag_pop;
  logic [CREQ-1:0] head_ctrl;
  logic [2:0]      head_type;
  logic            head_dom, head_permit;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign q_empty   = (cnt_q == '0);
  assign q_full    = (cnt_q == FULL_CNT);
  assign tag_empty = (tag_cnt_q == '0);
  assign tag_full  = (tag_cnt_q == FULL_CNT);

  assign head_ctrl = ctrl_mem_q[rd_ptr_q];
  assign head_type = head_ctrl[CREQ-1 -: 3];
  assign head_dom  = dom_mem_q[rd_ptr_q];
  // Reads may not look up past the slice level; writes may not push data down into it.
  assign head_permit = (head_type == 3'd0) ? (head_dom >= mem_sec_level)
                                           : (head_dom <= mem_sec_level);

  assign net_req_rdy     = reset & ~q_full;
  assign enq             = net_req_val & net_req_rdy;
  assign mem_req_val     = (state_q == S_PASS) & ~q_empty & head_permit & ~tag_full;
  assign mem_req_control = head_ctrl;
  assign mem_req_data    = data_mem_q[rd_ptr_q];
  assign tag_push        = mem_req_val & mem_req_rdy;
  assign deq             = tag_push | deq_deny;

  always_comb begin
    state_d          = state_q;
    net_resp_val     = 1'b0;
    mem_resp_rdy     = 1'b0;
    net_resp_control = mem_resp_control;
    net_resp_data    = mem_resp_data;
    net_resp_domain  = tag_mem_q[tag_rd_q];
    tag_pop          = 1'b0;
    deq_deny         = 1'b0;
    if (state_q == S_DENY) begin
      net_resp_val     = 1'b1;
      net_resp_control = {head_type, head_ctrl[CREQ-4 -: p_opaque_nbits], 4'd0};
      net_resp_data    = '0;
      net_resp_domain  = head_dom;
      if (net_resp_rdy) begin
        deq_deny = 1'b1;
        state_d  = S_PASS;
      end
    end else begin
      // With no tag outstanding a memory response has no owner and is swallowed.
      if (tag_empty) begin
        mem_resp_rdy = reset;
      end else begin
        net_resp_val = mem_resp_val;
        mem_resp_rdy = net_resp_rdy;
        tag_pop      = mem_resp_val & net_resp_rdy;
      end
      if (~q_empty & ~head_permit & tag_empty) state_d = S_DENY;
    end
  end

  always_comb begin
    wr_ptr_d  = enq      ? wrap_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = deq      ? wrap_inc(rd_ptr_q) : rd_ptr_q;
    tag_wr_d  = tag_push ? wrap_inc(tag_wr_q) : tag_wr_q;
    tag_rd_d  = tag_pop  ? wrap_inc(tag_rd_q) : tag_rd_q;
    cnt_d     = cnt_q;
    tag_cnt_d = tag_cnt_q;
    if (enq & ~deq)           cnt_d = cnt_q + 1'b1;
    else if (~enq & deq)      cnt_d = cnt_q - 1'b1;
    if (tag_push & ~tag_pop)  tag_cnt_d = tag_cnt_q + 1'b1;
    else if (~tag_push & tag_pop) tag_cnt_d = tag_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_PASS;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
      tag_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      tag_wr_q  <= tag_wr_d;
      tag_rd_q  <= tag_rd_d;
      tag_cnt_q <= tag_cnt_d;
    end
  end

  // Payload storage carries no reset; occupancy counters decide what is valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      ctrl_mem_q[wr_ptr_q] <= net_req_control;
      data_mem_q[wr_ptr_q] <= net_req_data;
      dom_mem_q[wr_ptr_q]  <= net_req_domain;
    end
    if (tag_push) tag_mem_q[tag_wr_q] <= head_dom;
  end

`ifdef PLAB5_MCORE_MEM_GUARD_STATS_EN
  logic [15:0] deny_count_q, deny_count_d;

  always_comb begin
    deny_count_d = deny_count_q;
    if (deq_deny && (deny_count_q != 16'hFFFF)) deny_count_d = deny_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) deny_count_q <= 16'd0;
    else        deny_count_q <= deny_count_d;
  end

  assign deny_count = deny_count_q;
`else
  assign deny_count = 16'd0;
`endif

endmodule
